// File: rtl/chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// chunk_serial_adder
//
// Multi-cycle adder/subtractor that processes CHUNK bits per clock. A
// WIDTH-bit operation takes N = WIDTH/CHUNK BUSY cycles, followed by a
// single DONE cycle. WIDTH must be an integer multiple of CHUNK, and CHUNK
// must be at least 1.
//
// Ports:
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous active-high reset
//   start  in   1      operation request (accepted in IDLE or DONE)
//   sub    in   1      0 = a + b + cin, 1 = a - b (cin ignored)
//   a      in   WIDTH  operand A (unsigned or two's complement)
//   b      in   WIDTH  operand B
//   cin    in   1      carry-in, add mode only
//   busy   out  1      high while chunks are being processed
//   done   out  1      one-cycle pulse: q/cout/ovf just updated
//   q      out  WIDTH  result, held until the next completion
//   cout   out  1      carry out of the MSB (subtract: 1 = no borrow)
//   ovf    out  1      signed two's-complement overflow
// -----------------------------------------------------------------------------
module chunk_serial_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic             cout,
  output logic             ovf
);

  localparam int N  = WIDTH / CHUNK;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] BUSY = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state;
  logic [CW-1:0]    cnt;
  logic             carry;
  // Operand copies are shifted right one chunk per cycle, so the chunk being
  // processed is always in the low CHUNK bits.
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH-1:0] b_reg;
  // Result shadow fills from the top; after N shifts every chunk sits at its
  // own bit position. Kept apart from q so q holds the previous result.
  logic [WIDTH-1:0] shadow;

  logic [CHUNK:0]   csum;
  logic             carry_msb;
  logic [WIDTH-1:0] shadow_next;
  logic             last;

  // NOTE: every variable written here gets a value on every path first,
  // otherwise synthesis infers a latch.
  always_comb begin
    csum        = '0;
    carry_msb   = 1'b0;
    shadow_next = '0;
    csum        = {1'b0, a_reg[CHUNK-1:0]} + {1'b0, b_reg[CHUNK-1:0]}
                + (CHUNK+1)'(carry);
    // Carry into the chunk's top bit, recovered from the sum bit.
    carry_msb   = a_reg[CHUNK-1] ^ b_reg[CHUNK-1] ^ csum[CHUNK-1];
    shadow_next = (shadow >> CHUNK)
                | (WIDTH'(csum[CHUNK-1:0]) << (WIDTH - CHUNK));
  end

  assign last = (cnt == CW'(N - 1));
  assign busy = (state == BUSY);
  assign done = (state == DONE);

  // NOTE: non-blocking assignments so every register samples pre-edge values
  // regardless of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      cnt    <= '0;
      carry  <= 1'b0;
      a_reg  <= '0;
      b_reg  <= '0;
      shadow <= '0;
      q      <= '0;
      cout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            a_reg <= a;
            b_reg <= sub ? ~b : b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
            state <= BUSY;
          end else begin
            state <= IDLE;
          end
        end
        BUSY: begin
          a_reg  <= a_reg >> CHUNK;
          b_reg  <= b_reg >> CHUNK;
          carry  <= csum[CHUNK];
          shadow <= shadow_next;
          cnt    <= cnt + CW'(1);
          if (last) begin
            q     <= shadow_next;
            cout  <= csum[CHUNK];
            ovf   <= carry_msb ^ csum[CHUNK];
            state <= DONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chunk_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_chunk_serial_adder
//
// Three instances (CHUNK = 4, 1, 16; WIDTH = 16) share clk and rst, each with
// its own stimulus and outputs. Directed steps exercise the CHUNK = 4 block;
// back-to-back random traffic runs on all three against an arithmetic model.
// -----------------------------------------------------------------------------
module tb_chunk_serial_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_v [3];
  logic        sub_v   [3];
  logic        cin_v   [3];
  logic [15:0] a_v     [3];
  logic [15:0] b_v     [3];
  logic        busy_v  [3];
  logic        done_v  [3];
  logic [15:0] q_v     [3];
  logic        cout_v  [3];
  logic        ovf_v   [3];

  // Last completed result per instance: {ovf, cout, q}.
  logic [17:0] exp_last [3];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  chunk_serial_adder #(.WIDTH(16), .CHUNK(4)) u_c4 (
    .clk(clk), .rst(rst), .start(start_v[0]), .sub(sub_v[0]),
    .a(a_v[0]), .b(b_v[0]), .cin(cin_v[0]), .busy(busy_v[0]),
    .done(done_v[0]), .q(q_v[0]), .cout(cout_v[0]), .ovf(ovf_v[0]));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(1)) u_c1 (
    .clk(clk), .rst(rst), .start(start_v[1]), .sub(sub_v[1]),
    .a(a_v[1]), .b(b_v[1]), .cin(cin_v[1]), .busy(busy_v[1]),
    .done(done_v[1]), .q(q_v[1]), .cout(cout_v[1]), .ovf(ovf_v[1]));

  chunk_serial_adder #(.WIDTH(16), .CHUNK(16)) u_c16 (
    .clk(clk), .rst(rst), .start(start_v[2]), .sub(sub_v[2]),
    .a(a_v[2]), .b(b_v[2]), .cin(cin_v[2]), .busy(busy_v[2]),
    .done(done_v[2]), .q(q_v[2]), .cout(cout_v[2]), .ovf(ovf_v[2]));

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the operand values.
  function automatic logic [17:0] ref_op(input logic [15:0] x, y,
                                         input logic s, c);
    int ux = int'(x);
    int uy = int'(y);
    int sx = int'($signed(x));
    int sy = int'($signed(y));
    int ci = int'(c);
    int sr;
    logic [15:0] r_q;
    logic r_cout, r_ovf;
    if (s) begin
      r_q    = 16'(ux - uy);
      r_cout = (ux >= uy);
      sr     = sx - sy;
    end else begin
      r_q    = 16'(ux + uy + ci);
      r_cout = ((ux + uy + ci) > 65535);
      sr     = sx + sy + ci;
    end
    r_ovf = (sr > 32767) || (sr < -32768);
    return {r_ovf, r_cout, r_q};
  endfunction

  task automatic check_result(input string tag, input int idx,
                              input logic [17:0] e);
    check({tag, " q"},    32'(q_v[idx]),    32'(e[15:0]));
    check({tag, " cout"}, 32'(cout_v[idx]), 32'(e[16]));
    check({tag, " ovf"},  32'(ovf_v[idx]),  32'(e[17]));
  endtask

  // One isolated operation with full latency and hold checks.
  task automatic run_op(input int idx, input int n, input logic [15:0] ta, tbv,
                        input logic ts, tc, input logic [17:0] e,
                        input string tag);
    a_v[idx] = ta; b_v[idx] = tbv; sub_v[idx] = ts; cin_v[idx] = tc;
    start_v[idx] = 1'b1;
    @(posedge clk); #1;
    start_v[idx] = 1'b0;
    a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom); cin_v[idx] = ~tc;
    for (int k = 0; k < n; k++) begin
      if (k > 0) begin @(posedge clk); #1; end
      check({tag, " busy"},   32'(busy_v[idx]), 32'd1);
      check({tag, " nodone"}, 32'(done_v[idx]), 32'd0);
      check({tag, " hold q"}, 32'(q_v[idx]),    32'(exp_last[idx][15:0]));
    end
    @(posedge clk); #1;
    check({tag, " done"},   32'(done_v[idx]), 32'd1);
    check({tag, " busy lo"}, 32'(busy_v[idx]), 32'd0);
    check_result(tag, idx, e);
    exp_last[idx] = e;
    @(posedge clk); #1;
    check({tag, " done 1cyc"}, 32'(done_v[idx]), 32'd0);
    check({tag, " idle"},      32'(busy_v[idx]), 32'd0);
    check({tag, " idle q"},    32'(q_v[idx]),    32'(e[15:0]));
  endtask

  // Back-to-back random operations with start held high throughout.
  task automatic b2b(input int idx, input int n, input int count);
    logic [17:0] e;
    a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom);
    sub_v[idx] = 1'($urandom); cin_v[idx] = 1'($urandom);
    start_v[idx] = 1'b1;
    for (int i = 0; i < count; i++) begin
      e = ref_op(a_v[idx], b_v[idx], sub_v[idx], cin_v[idx]);
      @(posedge clk); #1;
      a_v[idx] = 16'($urandom); b_v[idx] = 16'($urandom);
      sub_v[idx] = 1'($urandom); cin_v[idx] = 1'($urandom);
      for (int k = 0; k < n; k++) begin
        if (k > 0) begin @(posedge clk); #1; end
        check("b2b busy",   32'(busy_v[idx]), 32'd1);
        check("b2b hold q", 32'(q_v[idx]),    32'(exp_last[idx][15:0]));
      end
      @(posedge clk); #1;
      check("b2b done", 32'(done_v[idx]), 32'd1);
      check_result("b2b", idx, e);
      exp_last[idx] = e;
      if (i == count - 1) start_v[idx] = 1'b0;
    end
    @(posedge clk); #1;
    check("b2b end idle", 32'(busy_v[idx] | done_v[idx]), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int ndone;
    logic [17:0] e1;

    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      start_v[i] = 1'b0; sub_v[i] = 1'b0; cin_v[i] = 1'b0;
      a_v[i] = '0; b_v[i] = '0; exp_last[i] = '0;
    end
    // Start held together with reset: reset must win.
    start_v[0] = 1'b1; a_v[0] = 16'h1234; b_v[0] = 16'h4321;
    repeat (2) @(posedge clk);
    #1;
    check("rst busy", 32'(busy_v[0]), 32'd0);
    check("rst done", 32'(done_v[0]), 32'd0);
    check_result("rst", 0, 18'h00000);
    start_v[0] = 1'b0;
    rst = 1'b0;

    // First start after reset is taken on the first edge with rst low.
    run_op(0, 4, 16'h1234, 16'h4321, 1'b0, 1'b0, 18'h05555, "add basic");
    run_op(0, 4, 16'hFFFF, 16'h0001, 1'b0, 1'b0, 18'h10000, "add wrap");
    run_op(0, 4, 16'h7FFF, 16'h0001, 1'b0, 1'b0, 18'h28000, "add ovf");
    run_op(0, 4, 16'h0005, 16'h0007, 1'b1, 1'b1, 18'h0FFFE, "sub borrow");
    run_op(0, 4, 16'h8000, 16'h0001, 1'b1, 1'b1, 18'h37FFF, "sub ovf");
    run_op(0, 4, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 18'h10000, "add cin");

    // Start during BUSY is ignored.
    e1 = 18'h03333;
    a_v[0] = 16'h1111; b_v[0] = 16'h2222; sub_v[0] = 1'b0; cin_v[0] = 1'b0;
    start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    start_v[0] = 1'b1; a_v[0] = 16'hAAAA; b_v[0] = 16'h5555;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) begin
        ndone++;
        check_result("busy start", 0, e1);
      end
    end
    check("busy start ndone", 32'(ndone), 32'd1);
    exp_last[0] = e1;

    // Reset in the 3rd BUSY cycle aborts the operation.
    a_v[0] = 16'h1357; b_v[0] = 16'h2468; start_v[0] = 1'b1;
    @(posedge clk); #1;
    start_v[0] = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("abort pre busy", 32'(busy_v[0]), 32'd1);
    rst = 1'b1;
    #1;
    check("abort busy", 32'(busy_v[0]), 32'd0);
    check("abort done", 32'(done_v[0]), 32'd0);
    check_result("abort", 0, 18'h00000);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) exp_last[i] = '0;
    ndone = 0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (done_v[0]) ndone++;
    end
    check("abort no done", 32'(ndone), 32'd0);
    run_op(0, 4, 16'h00FF, 16'h0F01, 1'b0, 1'b0, 18'h01000, "after abort");

    // Back-to-back random traffic at CHUNK = 4, 1, 16.
    b2b(0, 4, 100);
    b2b(1, 16, 100);
    b2b(2, 1, 100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
